// File: rtl/udt_conn_fsm_if.sv
// udt_conn_fsm_if
//   Handshake bundle between the connection sequencer and the UDT protocol engine.
//   master : sequencer side (drives requests, status-ready and peer-close acknowledge)
//   slave  : engine side    (drives responses, status beats and peer-close requests)
//   Signals:
//     Req_Connect / Res_Connect   connect request (held) / engine accept pulse
//     Req_Close   / Res_Close     close request (held) / engine accept pulse
//     udt_state, state_valid,     engine status beat (bit 4 ESTABLISHED, bit 12 CLOSED)
//     state_ready
//     Peer_Req_Close              one-cycle pulse: peer requested close
//     Peer_Res_Close              one-cycle pulse: peer close acknowledged
interface udt_conn_fsm_if;
    logic        Req_Connect;
    logic        Res_Connect;
    logic        Req_Close;
    logic        Res_Close;
    logic [31:0] udt_state;
    logic        state_valid;
    logic        state_ready;
    logic        Peer_Req_Close;
    logic        Peer_Res_Close;

    modport master (
        output Req_Connect, Req_Close, state_ready, Peer_Res_Close,
        input  Res_Connect, Res_Close, udt_state, state_valid, Peer_Req_Close
    );

    modport slave (
        input  Req_Connect, Req_Close, state_ready, Peer_Res_Close,
        output Res_Connect, Res_Close, udt_state, state_valid, Peer_Req_Close
    );
endinterface

// File: rtl/udt_conn_fsm.sv
// udt_conn_fsm
//   Connection-lifecycle sequencer between the configure register block and the
//   UDT protocol engine. Turns one-cycle connect/close commands into held
//   request/response handshakes, confirms ESTABLISHED/CLOSED from engine status
//   beats with a timeout and bounded connect retry, and forwards peer-initiated
//   close to the user through a valid/ready handshake.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     cfg_connect       one-cycle connect command
//     cfg_close         one-cycle close command
//     cfg_params_ok     level: configured parameters are in range
//     eng               engine handshake bundle (master side)
//     user_valid/ready  peer-close notification handshake
//     conn_state        current state encoding
//     err, err_code     sticky error flag and cause (01 params, 10 connect tmo, 11 close tmo)
//     retry_cnt         connect retries used in the current attempt
//   All outputs are registered.
module udt_conn_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_connect,
    input  logic                  cfg_close,
    input  logic                  cfg_params_ok,
    udt_conn_fsm_if.master        eng,
    output logic                  user_valid,
    input  logic                  user_ready,
    output logic [2:0]            conn_state,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [1:0]            retry_cnt
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        CONNECTING   = 3'd1,
        WAIT_EST     = 3'd2,
        ESTABLISHED  = 3'd3,
        CLOSING      = 3'd4,
        WAIT_CLOSED  = 3'd5,
        PEER_CLOSING = 3'd6
    } state_t;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        req_conn_q, req_conn_d;
    logic        req_close_q, req_close_d;
    logic        uvalid_q, uvalid_d;
    logic        peer_res_q, peer_res_d;
    logic        err_q, err_d;
    logic [1:0]  ec_q, ec_d;
    logic [1:0]  rt_q, rt_d;
    logic        ready_q;
    logic [31:0] timer_q, timer_d;
    logic        beat;
    logic        unused_status_bits;

    assign beat = eng.state_valid & ready_q;

    // Only the ESTABLISHED and CLOSED flags of the status word matter here.
    assign unused_status_bits = ^{eng.udt_state[31:13], eng.udt_state[11:5], eng.udt_state[3:0]};

    always_comb begin
        state_d     = state_q;
        req_conn_d  = req_conn_q;
        req_close_d = req_close_q;
        uvalid_d    = uvalid_q;
        peer_res_d  = peer_res_q;
        err_d       = err_q;
        ec_d        = ec_q;
        rt_d        = rt_q;
        timer_d     = timer_q;

        case (state_q)
            IDLE: begin
                if (cfg_connect) begin
                    if (cfg_params_ok) begin
                        state_d    = CONNECTING;
                        req_conn_d = 1'b1;
                        err_d      = 1'b0;
                        rt_d       = '0;
                    end else begin
                        err_d = 1'b1;
                        ec_d  = 2'b01;
                    end
                end
            end
            CONNECTING: begin
                if (eng.Res_Connect && req_conn_q) begin
                    req_conn_d = 1'b0;
                    state_d    = WAIT_EST;
                    timer_d    = '0;
                end
            end
            WAIT_EST: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 32'd1;
                // An accepted ESTABLISHED beat takes priority over a coincident timeout.
                if (beat && eng.udt_state[4]) begin
                    state_d = ESTABLISHED;
                end else if (timer_q == TMO_LAST) begin
                    if (rt_q < RETRY_MAX) begin
                        rt_d       = rt_q + 2'd1;
                        state_d    = CONNECTING;
                        req_conn_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        ec_d    = 2'b10;
                    end
                end
            end
            ESTABLISHED: begin
                if (cfg_close) begin
                    state_d     = CLOSING;
                    req_close_d = 1'b1;
                end else if (eng.Peer_Req_Close) begin
                    state_d  = PEER_CLOSING;
                    uvalid_d = 1'b1;
                end
            end
            CLOSING: begin
                if (eng.Res_Close && req_close_q) begin
                    req_close_d = 1'b0;
                    state_d     = WAIT_CLOSED;
                    timer_d     = '0;
                end
            end
            WAIT_CLOSED: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 32'd1;
                if (beat && eng.udt_state[12]) begin
                    state_d = IDLE;
                    rt_d    = '0;
                end else if (timer_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    ec_d    = 2'b11;
                end
            end
            PEER_CLOSING: begin
                // Stays one extra cycle here while the acknowledge pulse is out.
                if (peer_res_q) begin
                    peer_res_d = 1'b0;
                    state_d    = IDLE;
                end else if (user_ready && uvalid_q) begin
                    uvalid_d   = 1'b0;
                    peer_res_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_conn_d  = 1'b0;
                req_close_d = 1'b0;
                uvalid_d    = 1'b0;
                peer_res_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_conn_q  <= 1'b0;
            req_close_q <= 1'b0;
            uvalid_q    <= 1'b0;
            peer_res_q  <= 1'b0;
            err_q       <= 1'b0;
            ec_q        <= '0;
            rt_q        <= '0;
            ready_q     <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_conn_q  <= req_conn_d;
            req_close_q <= req_close_d;
            uvalid_q    <= uvalid_d;
            peer_res_q  <= peer_res_d;
            err_q       <= err_d;
            ec_q        <= ec_d;
            rt_q        <= rt_d;
            ready_q     <= 1'b1;
            timer_q     <= timer_d;
        end
    end

    assign eng.Req_Connect    = req_conn_q;
    assign eng.Req_Close      = req_close_q;
    assign eng.state_ready    = ready_q;
    assign eng.Peer_Res_Close = peer_res_q;
    assign user_valid         = uvalid_q;
    assign conn_state         = state_q;
    assign err                = err_q;
    assign err_code           = ec_q;
    assign retry_cnt          = rt_q;

endmodule

// File: tb/tb_udt_conn_fsm.sv
// tb_udt_conn_fsm
//   Randomized bench for udt_conn_fsm. The driver issues connection-level
//   transactions (connect with a chosen number of timeouts, local close ending in
//   CLOSED / timeout / reset, peer close, bad parameters) interleaved with input
//   pulses that must be ignored in the current state. For every transaction it
//   predicts, from the protocol rules, each change of the DUT output vector and
//   the cycle in which it must appear, and queues it. An independent monitor
//   watches the outputs and pops/compares the queue whenever they change.
module tb_udt_conn_fsm;
    localparam int TMO  = 20;
    localparam int MAXR = 2;

    typedef struct packed {
        logic [2:0] cs;
        logic       rc;
        logic       rcl;
        logic       uv;
        logic       prc;
        logic       err;
        logic [1:0] ec;
        logic [1:0] rt;
        logic       sr;
    } outv_t;

    typedef struct {
        outv_t v;
        int    stamp;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cfg_connect;
    logic       cfg_close;
    logic       cfg_params_ok;
    logic       user_valid;
    logic       user_ready;
    logic [2:0] conn_state;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] retry_cnt;

    udt_conn_fsm_if eng_if ();

    udt_conn_fsm #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_connect  (cfg_connect),
        .cfg_close    (cfg_close),
        .cfg_params_ok(cfg_params_ok),
        .eng          (eng_if),
        .user_valid   (user_valid),
        .user_ready   (user_ready),
        .conn_state   (conn_state),
        .err          (err),
        .err_code     (err_code),
        .retry_cnt    (retry_cnt)
    );

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    bit    mon_en = 0;
    exp_t  sbq[$];
    outv_t m;
    outv_t last;
    outv_t prev;
    outv_t cur;
    exp_t  e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output vector is one observed event.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {conn_state, eng_if.Req_Connect, eng_if.Req_Close, user_valid,
                   eng_if.Peer_Res_Close, err, err_code, retry_cnt, eng_if.state_ready};
            if (cur !== prev) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got vec=%h at cycle %0d, required no change", cur, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (cur !== e.v || cyc != e.stamp) begin
                        bad++;
                        $display("FAIL event_%0d: got vec=%h cycle=%0d, required vec=%h cycle=%0d",
                                 total, cur, cyc, e.v, e.stamp);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cfg_connect           = 1'b0;
        cfg_close             = 1'b0;
        user_ready            = 1'b0;
        eng_if.Res_Connect    = 1'b0;
        eng_if.Res_Close      = 1'b0;
        eng_if.Peer_Req_Close = 1'b0;
        eng_if.state_valid    = 1'b0;
    endtask

    // Queue the model's output vector if it differs from the last one predicted.
    task automatic exp_at(input int st);
        if (m !== last) begin
            sbq.push_back('{v: m, stamp: st});
            last = m;
        end
    endtask

    // One cycle of inputs that the rules say must have no effect in state st.
    task automatic noise(input int st);
        logic [6:0]  allow;
        logic [31:0] forbid;
        forbid = '0;
        case (st)
            0:       allow = 7'b1111110;
            1:       allow = 7'b1110111;
            2:       begin allow = 7'b1111111; forbid = 32'h0000_0010; end
            3:       allow = 7'b1111001;
            4:       allow = 7'b1101111;
            5:       begin allow = 7'b1111111; forbid = 32'h0000_1000; end
            default: allow = 7'b1011111;
        endcase
        cfg_params_ok         = 1'($urandom_range(0, 1));
        cfg_connect           = allow[0] && ($urandom_range(0, 3) == 0);
        cfg_close             = allow[1] && ($urandom_range(0, 3) == 0);
        eng_if.Peer_Req_Close = allow[2] && ($urandom_range(0, 3) == 0);
        eng_if.Res_Connect    = allow[3] && ($urandom_range(0, 3) == 0);
        eng_if.Res_Close      = allow[4] && ($urandom_range(0, 3) == 0);
        user_ready            = allow[5] && ($urandom_range(0, 3) == 0);
        eng_if.state_valid    = allow[6] && ($urandom_range(0, 2) == 0);
        eng_if.udt_state      = $urandom & ~forbid;
        tick();
        clr();
    endtask

    task automatic noise_n(input int st, input int n);
        for (int i = 0; i < n; i++) noise(st);
    endtask

    task automatic t_reset();
        rst_n = 1'b0;
        m = '0;
        exp_at(cyc + 1);
        tick();
        rst_n = 1'b1;
        m.sr = 1'b1;
        exp_at(cyc + 1);
        tick();
    endtask

    task automatic t_bad();
        noise_n(0, $urandom_range(0, 3));
        cfg_params_ok = 1'b0;
        cfg_connect   = 1'b1;
        m.err = 1'b1;
        m.ec  = 2'b01;
        exp_at(cyc + 1);
        tick();
        clr();
    endtask

    // Connect attempt that sees ntmo status timeouts; ntmo > MAXR ends in failure.
    task automatic t_connect(input int ntmo);
        int w;
        noise_n(0, $urandom_range(0, 3));
        cfg_params_ok         = 1'b1;
        cfg_connect           = 1'b1;
        cfg_close             = 1'($urandom_range(0, 1));
        eng_if.Peer_Req_Close = 1'($urandom_range(0, 1));
        m.cs  = 3'd1;
        m.rc  = 1'b1;
        m.err = 1'b0;
        m.rt  = 2'd0;
        exp_at(cyc + 1);
        tick();
        clr();
        for (int a = 0; a <= ntmo; a++) begin
            noise_n(1, $urandom_range(0, 4));
            eng_if.Res_Connect = 1'b1;
            m.cs = 3'd2;
            m.rc = 1'b0;
            exp_at(cyc + 1);
            tick();
            clr();
            w = cyc;
            if (a < ntmo) begin
                while (cyc < w + TMO - 1) noise(2);
                if (a < MAXR) begin
                    m.rt = 2'(a + 1);
                    m.cs = 3'd1;
                    m.rc = 1'b1;
                    exp_at(w + TMO);
                    tick();
                end else begin
                    m.cs  = 3'd0;
                    m.err = 1'b1;
                    m.ec  = 2'b10;
                    exp_at(w + TMO);
                    tick();
                    return;
                end
            end else begin
                noise_n(2, $urandom_range(0, 14));
                eng_if.state_valid = 1'b1;
                eng_if.udt_state   = $urandom | 32'h0000_0010;
                m.cs = 3'd3;
                exp_at(cyc + 1);
                tick();
                clr();
            end
        end
    endtask

    // Local close from ESTABLISHED. mode 0: CLOSED beat, 1: timeout, 2: reset in CLOSING.
    task automatic t_close(input int mode, input bit peer_too);
        int w;
        noise_n(3, $urandom_range(0, 3));
        cfg_close             = 1'b1;
        eng_if.Peer_Req_Close = peer_too;
        m.cs  = 3'd4;
        m.rcl = 1'b1;
        exp_at(cyc + 1);
        tick();
        clr();
        noise_n(4, $urandom_range(0, 4));
        if (mode == 2) begin
            t_reset();
            return;
        end
        eng_if.Res_Close = 1'b1;
        m.cs  = 3'd5;
        m.rcl = 1'b0;
        exp_at(cyc + 1);
        tick();
        clr();
        w = cyc;
        if (mode == 1) begin
            while (cyc < w + TMO - 1) noise(5);
            m.cs  = 3'd0;
            m.err = 1'b1;
            m.ec  = 2'b11;
            exp_at(w + TMO);
            tick();
        end else begin
            noise_n(5, $urandom_range(0, 14));
            eng_if.state_valid = 1'b1;
            eng_if.udt_state   = $urandom | 32'h0000_1000;
            m.cs = 3'd0;
            m.rt = 2'd0;
            exp_at(cyc + 1);
            tick();
            clr();
        end
    endtask

    task automatic t_peer();
        noise_n(3, $urandom_range(0, 3));
        eng_if.Peer_Req_Close = 1'b1;
        m.cs = 3'd6;
        m.uv = 1'b1;
        exp_at(cyc + 1);
        tick();
        clr();
        noise_n(6, $urandom_range(0, 4));
        user_ready = 1'b1;
        m.uv  = 1'b0;
        m.prc = 1'b1;
        exp_at(cyc + 1);
        m.cs  = 3'd0;
        m.prc = 1'b0;
        exp_at(cyc + 2);
        tick();
        clr();
        tick();
    endtask

    initial begin
        int k;
        int sel;
        rst_n            = 1'b0;
        cfg_params_ok    = 1'b0;
        eng_if.udt_state = '0;
        clr();
        m    = '0;
        last = 'x;
        prev = 'x;
        repeat (3) tick();
        exp_at(cyc);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        m.sr   = 1'b1;
        exp_at(cyc + 1);
        tick();

        repeat (2) begin
            t_connect(0);
            t_close(0, 1'b0);
        end
        t_bad();
        t_connect(MAXR + 1);
        t_connect(0);
        t_peer();
        t_connect(1);
        t_close(0, 1'b1);
        t_connect(2);
        t_close(2, 1'b0);
        t_connect(0);
        t_close(1, 1'b0);

        repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
                t_bad();
            end else begin
                k = $urandom_range(0, MAXR + 1);
                t_connect(k);
                if (k <= MAXR) begin
                    sel = $urandom_range(0, 4);
                    case (sel)
                        0:       t_peer();
                        1:       t_close(1, 1'($urandom_range(0, 1)));
                        2:       t_close(2, 1'($urandom_range(0, 1)));
                        default: t_close(0, 1'($urandom_range(0, 1)));
                    endcase
                end
            end
        end

        repeat (5) tick();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d unobserved, required 0 (next at cycle %0d)",
                     sbq.size(), sbq[0].stamp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end by cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/udt_conn_fsm.md
# udt_conn_fsm

Connection-lifecycle sequencer between the AXI4-Lite configure register block and the UDT protocol engine. Converts the one-cycle connect/close commands raised by register writes (addresses 0x5/0x6) into held request/response handshakes with the engine. Tracks engine status beats to confirm ESTABLISHED/CLOSED, with timeout and bounded retry. Also services peer-initiated close through a user-visible valid/ready handshake.

## Interface
- TIMEOUT_CYCLES, 100000: cycles to wait for an engine status beat before timeout; must be ≥ 2.
- MAX_RETRY, 3: connect re-attempts after timeout before failing; width of `retry_cnt` is 2 bits, so MAX_RETRY ≤ 3.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_connect  in  1  one-cycle connect command from the configure block.
- cfg_close  in  1  one-cycle close command from the configure block.
- cfg_params_ok  in  1  level; high when all configured parameters are in range.
- Req_Connect  out  1  connect request to the engine; held until Res_Connect.
- Res_Connect  in  1  engine accept pulse for a connect request.
- Req_Close  out  1  close request to the engine; held until Res_Close.
- Res_Close  in  1  engine accept pulse for a close request.
- udt_state  in  32  engine status word. Bit 4 = ESTABLISHED, bit 12 = CLOSED.
- state_valid  in  1  status beat valid.
- state_ready  out  1  status beat ready.
- Peer_Req_Close  in  1  one-cycle pulse: peer requested close.
- user_valid  out  1  peer-close notification to the user.
- user_ready  in  1  user acknowledges the notification.
- Peer_Res_Close  out  1  one-cycle pulse: peer close acknowledged to the engine.
- conn_state  out  3  current FSM state encoding.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 01 = params bad, 10 = connect timeout, 11 = close timeout.
- retry_cnt  out  2  connect retries used in the current attempt.

## Operation
- State encodings: IDLE=0, CONNECTING=1, WAIT_EST=2, ESTABLISHED=3, CLOSING=4, WAIT_CLOSED=5, PEER_CLOSING=6. Encodings 7 and above are unreachable and recover to IDLE.
- IDLE
  - cfg_connect with cfg_params_ok=1 → CONNECTING; Req_Connect=1; err cleared; retry_cnt=0.
  - cfg_connect with cfg_params_ok=0 → stay in IDLE; err=1; err_code=01.
  - cfg_close and Peer_Req_Close are ignored.
- CONNECTING: hold Req_Connect until Res_Connect is sampled high. Then deassert Req_Connect, go to WAIT_EST, clear the timer.
- WAIT_EST
  - Accepted beat with udt_state[4]=1 → ESTABLISHED.
  - Timer reaches TIMEOUT_CYCLES-1 with retry_cnt<MAX_RETRY → retry_cnt+1, return to CONNECTING, reassert Req_Connect.
  - Timer reaches TIMEOUT_CYCLES-1 otherwise → IDLE; err=1; err_code=10.
- ESTABLISHED
  - cfg_close → CLOSING; Req_Close=1.
  - Peer_Req_Close → PEER_CLOSING; user_valid=1.
  - Both in the same cycle: the local close wins and the peer pulse is dropped.
  - cfg_connect is ignored.
- CLOSING: hold Req_Close until Res_Close is sampled high. Then deassert Req_Close, go to WAIT_CLOSED, clear the timer.
- WAIT_CLOSED
  - Accepted beat with udt_state[12]=1 → IDLE; retry_cnt=0.
  - Timeout → IDLE; err=1; err_code=11.
- PEER_CLOSING: hold user_valid until user_ready is sampled high. Then user_valid=0, Peer_Res_Close=1 for exactly one cycle, go to IDLE.
- Status channel: state_ready=1 in every state after reset. Beats in states other than WAIT_EST/WAIT_CLOSED, or without the relevant bit set, are consumed and ignored.
- Timer: 32-bit counter. Cleared on entry to WAIT_EST/WAIT_CLOSED, increments each cycle in those states, never wraps.
- Command pulses arriving in any state not listed above are dropped; they are not queued.

## Timing
- All outputs are registered.
- Reset values: every output 0, conn_state=IDLE; state_ready is 0 during reset and 1 from the first cycle after rst_n rises.
- Reset mid-operation: any state → IDLE next edge. Req_Connect, Req_Close, user_valid and Peer_Res_Close drop immediately; err, err_code and retry_cnt clear.
- cfg_connect sampled at edge N → Req_Connect high after edge N, i.e. visible in cycle N+1.
- Res_Connect sampled at edge M → Req_Connect low and conn_state=WAIT_EST after edge M. Res_Close is symmetric.
- A status beat is accepted on an edge where state_valid & state_ready; the state update is visible the next cycle.
- Timeout: WAIT_EST entered at edge E with no beat → action at edge E+TIMEOUT_CYCLES.
- user_ready sampled at edge U → user_valid=0 and Peer_Res_Close=1 in cycle U+1; Peer_Res_Close=0 and conn_state=IDLE in cycle U+2.
- Res_Connect or Res_Close asserted while its matching request is low is ignored.

## Test plan
- Connect/close: params ok, cfg_connect → Req_Connect=1 next cycle. Res_Connect pulse → WAIT_EST. Beat 0x0000_0010 → conn_state=3. cfg_close → Req_Close=1. Res_Close, then beat 0x0000_1000 → conn_state=0, err=0. Repeat the sequence twice.
- Bad params: cfg_params_ok=0, cfg_connect → Req_Connect stays 0; err=1; err_code=01; conn_state=0.
- Retry/timeout with TIMEOUT_CYCLES=20, MAX_RETRY=2, no status beats → three Req_Connect assertions; retry_cnt reaches 2; then IDLE with err_code=10 at the expected cycle.
- Peer close: in ESTABLISHED, pulse Peer_Req_Close → user_valid=1 next cycle. user_ready pulse → Peer_Res_Close one-cycle pulse, then conn_state=0.
- Simultaneous cfg_close and Peer_Req_Close in ESTABLISHED → Req_Close=1, user_valid stays 0, conn_state=4.
- Reset in CLOSING with Req_Close=1: drive rst_n=0 for one edge → all outputs 0, conn_state=0. A subsequent normal connect succeeds.
